// File: rtl/game_state_uart_tx_if.sv
// Snapshot/request bundle and UART line for game_state_uart_tx.
// The master drives send and the game state. The slave is the transmitter.
interface game_state_uart_tx_if;
  logic       send;
  logic [1:0] correct_door_1;
  logic [1:0] correct_door_2;
  logic [1:0] player_1_pos;
  logic [1:0] player_2_pos;
  logic [1:0] p1_lives;
  logic [1:0] p2_lives;
  logic       time_up;
  logic       serial_out;
  logic       busy;
  logic       done;

  modport master (
    output send, correct_door_1, correct_door_2, player_1_pos, player_2_pos,
           p1_lives, p2_lives, time_up,
    input  serial_out, busy, done
  );

  modport slave (
    input  send, correct_door_1, correct_door_2, player_1_pos, player_2_pos,
           p1_lives, p2_lives, time_up,
    output serial_out, busy, done
  );
endinterface

// File: rtl/game_state_uart_tx.sv
// 8N1 UART sender of {HEADER, state, status} game-state packets; the start bit appears one edge after send is seen in IDLE.
// A send arriving while busy or during done is dropped, not queued. PACKET_CHECKSUM_EN appends an XOR checksum byte.
module game_state_uart_tx #(
  parameter int         CLKS_PER_BIT = 217,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  game_state_uart_tx_if.slave  tx_if
);

`ifdef PACKET_CHECKSUM_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(NBYTES - 1);

  typedef struct packed {
    logic [7:0] state_byte;
    logic [7:0] status_byte;
  } snap_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  snap_t             snap_q, snap_d;
  logic              serial_q, serial_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_wrap;
  logic [7:0]        tx_byte;

  assign baud_wrap = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    snap_d  = snap_q;
    case (state_q)
      S_IDLE: begin
        if (tx_if.send) begin
          state_d            = S_START;
          baud_d             = '0;
          bit_d              = '0;
          byte_d             = '0;
          snap_d.state_byte  = {tx_if.correct_door_1, tx_if.correct_door_2,
                                tx_if.player_1_pos, tx_if.player_2_pos};
          snap_d.status_byte = {3'b000, tx_if.time_up, tx_if.p1_lives, tx_if.p2_lives};
        end
      end
      S_START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          bit_d  = '0;
          // Next byte starts immediately; only the last stop bit leads to DONE.
          if (byte_q == LAST_BYTE) begin
            state_d = S_DONE;
            byte_d  = '0;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 2'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
      end
    endcase
  end

  always_comb begin
    case (byte_d)
      2'd0:    tx_byte = HEADER;
      2'd1:    tx_byte = snap_q.state_byte;
      2'd2:    tx_byte = snap_q.status_byte;
`ifdef PACKET_CHECKSUM_EN
      default: tx_byte = HEADER ^ snap_q.state_byte ^ snap_q.status_byte;
`else
      default: tx_byte = HEADER;
`endif
    endcase
  end

  // Outputs are decoded from the next state so the line is driven straight from a flop.
  always_comb begin
    serial_d = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      S_START: begin
        serial_d = 1'b0;
        busy_d   = 1'b1;
      end
      S_DATA: begin
        serial_d = tx_byte[bit_d];
        busy_d   = 1'b1;
      end
      S_STOP: begin
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        serial_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      snap_q   <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      snap_q   <= snap_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_if.serial_out = serial_q;
  assign tx_if.busy       = busy_q;
  assign tx_if.done       = done_q;

endmodule

// File: tb/tb_game_state_uart_tx.sv
// Scoreboard bench for game_state_uart_tx at CLKS_PER_BIT=4: stimulus queues expected bytes, done cycles and point checks.
module tb_game_state_uart_tx;
  localparam int CPB = 4;
`ifdef PACKET_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  localparam int LEN = NB * 10 * CPB;
  localparam int PER = LEN + 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  game_state_uart_tx_if gif();

  game_state_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .HEADER      (8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .tx_if(gif)
  );

  typedef struct {
    int    cyc;
    logic  so;
    logic  busy;
    logic  done;
    string name;
  } pchk_t;

  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  pchk_t      pc_q[$];
  logic [7:0] byte_q[$];
  int         done_q[$];
  bit         final_chk  = 1'b0;
  bit         final_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: point checks, done timing and a mid-bit UART decoder.
  pchk_t      p;
  int         exp_c;
  logic [7:0] exp_b;
  bit         rx_active = 1'b0;
  int         rx_off    = 0;
  logic [7:0] rx_byte   = 8'h00;

  always @(negedge clk) begin
    while (pc_q.size() > 0 && pc_q[0].cyc <= cyc) begin
      p = pc_q.pop_front();
      checks++;
      if (p.cyc != cyc) begin
        errors++;
        $display("FAIL %s: check for cycle %0d missed at cycle %0d", p.name, p.cyc, cyc);
      end else if ({gif.serial_out, gif.busy, gif.done} !== {p.so, p.busy, p.done}) begin
        errors++;
        $display("FAIL %s @%0d: serial/busy/done=%b%b%b want %b%b%b", p.name, cyc,
                 gif.serial_out, gif.busy, gif.done, p.so, p.busy, p.done);
      end
    end
    if (reset) begin
      rx_active = 1'b0;
    end else begin
      if (gif.done === 1'b1) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done @%0d: done=1 want no done", cyc);
        end else begin
          exp_c = done_q.pop_front();
          if (exp_c != cyc || gif.busy !== 1'b0 || gif.serial_out !== 1'b1) begin
            errors++;
            $display("FAIL done_timing: done at %0d busy=%b serial=%b want cycle %0d busy=0 serial=1",
                     cyc, gif.busy, gif.serial_out, exp_c);
          end
        end
      end
      if (!rx_active) begin
        if (gif.serial_out === 1'b0) begin
          rx_active = 1'b1;
          rx_off    = 0;
        end
      end else begin
        rx_off++;
        if (rx_off >= 6 && rx_off <= 34 && ((rx_off - 6) % CPB) == 0)
          rx_byte = {gif.serial_out, rx_byte[7:1]};
        if (rx_off == 38) begin
          rx_active = 1'b0;
          checks++;
          if (byte_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte @%0d: got %h want no byte", cyc, rx_byte);
          end else begin
            exp_b = byte_q.pop_front();
            if (rx_byte !== exp_b || gif.serial_out !== 1'b1) begin
              errors++;
              $display("FAIL byte @%0d: got %h stop=%b want %h stop=1", cyc, rx_byte, gif.serial_out, exp_b);
            end
          end
        end
      end
    end
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      checks++;
      if (pc_q.size() != 0 || byte_q.size() != 0 || done_q.size() != 0) begin
        errors++;
        $display("FAIL leftovers: points=%0d bytes=%0d dones=%0d want 0 0 0",
                 pc_q.size(), byte_q.size(), done_q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_chk(input int c, input logic so, input logic b, input logic d, input string nm);
    pchk_t t;
    t.cyc  = c;
    t.so   = so;
    t.busy = b;
    t.done = d;
    t.name = nm;
    pc_q.push_back(t);
  endtask

  task automatic set_state(input logic [1:0] d1, input logic [1:0] d2, input logic [1:0] p1,
                           input logic [1:0] p2, input logic [1:0] l1, input logic [1:0] l2,
                           input logic tu);
    gif.correct_door_1 = d1;
    gif.correct_door_2 = d2;
    gif.player_1_pos   = p1;
    gif.player_2_pos   = p2;
    gif.p1_lives       = l1;
    gif.p2_lives       = l2;
    gif.time_up        = tu;
  endtask

  task automatic push_bytes(input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] ck;
    ck = 8'hA5 ^ b1 ^ b2;
    byte_q.push_back(8'hA5);
    byte_q.push_back(b1);
    byte_q.push_back(b2);
    if (NB == 4) byte_q.push_back(ck);
  endtask

  task automatic send_pkt(input logic [7:0] b1, input logic [7:0] b2, input bit exp_done, output int n);
    tick();
    gif.send = 1'b1;
    n = cyc;
    push_bytes(b1, b2);
    if (exp_done) done_q.push_back(n + 1 + LEN);
    tick();
    gif.send = 1'b0;
  endtask

  int n;
  int n2;

  initial begin
    gif.send = 1'b0;
    set_state(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // Reset then long idle.
    repeat (3) tick();
    push_chk(cyc, 1'b1, 1'b0, 1'b0, "reset_state");
    reset = 1'b0;
    for (int i = 1; i <= 50; i++) push_chk(cyc + i, 1'b1, 1'b0, 1'b0, "idle_after_reset");
    goto(cyc + 52);

    // Basic packet: bytes A5 4B 1B (checksum F5).
    set_state(2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 1'b1);
    send_pkt(8'h4B, 8'h1B, 1'b1, n);
    push_chk(n + 1,       1'b0, 1'b1, 1'b0, "start_bit");
    push_chk(n + LEN,     1'b1, 1'b1, 1'b0, "last_stop");
    push_chk(n + LEN + 1, 1'b1, 1'b0, 1'b1, "done_pulse");
    push_chk(n + LEN + 2, 1'b1, 1'b0, 1'b0, "idle_after_done");
    goto(n + LEN + 10);

    // Snapshot hold: inputs cleared during byte0.
    send_pkt(8'h4B, 8'h1B, 1'b1, n);
    goto(n + 5);
    set_state(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    goto(n + LEN + 10);

    // Ignored sends mid-packet: B1 04.
    set_state(2'b10, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0);
    send_pkt(8'hB1, 8'h04, 1'b1, n);
    goto(n + 30);
    gif.send = 1'b1;
    tick();
    gif.send = 1'b0;
    goto(n + 90);
    gif.send = 1'b1;
    tick();
    gif.send = 1'b0;
    push_chk(n + LEN + 1, 1'b1, 1'b0, 1'b1, "ignored_done");
    for (int i = 2; i <= 40; i++) push_chk(n + LEN + i, 1'b1, 1'b0, 1'b0, "no_second_packet");
    goto(n + LEN + 45);

    // Back-to-back: send held 300 cycles, bytes E4 11.
    set_state(2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
    tick();
    gif.send = 1'b1;
    n = cyc;
    for (int k = 0; 1 + k * PER <= 300; k++) begin
      push_bytes(8'hE4, 8'h11);
      done_q.push_back(n + 1 + k * PER + LEN);
      push_chk(n + 1 + k * PER,           1'b0, 1'b1, 1'b0, "b2b_start");
      push_chk(n + 1 + k * PER + LEN + 1, 1'b1, 1'b0, 1'b0, "b2b_idle_gap");
      n2 = n + 1 + k * PER + LEN + 10;
    end
    goto(n + 300);
    gif.send = 1'b0;
    goto(n2);

    // Reset mid-frame during byte1, then a clean packet.
    set_state(2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 1'b1);
    send_pkt(8'h4B, 8'h1B, 1'b0, n);
    push_chk(n + 1, 1'b0, 1'b1, 1'b0, "rst_mid_start");
    goto(n + 45);
    reset = 1'b1;
    byte_q.delete();
    push_chk(n + 46, 1'b1, 1'b0, 1'b0, "rst_mid_line");
    tick();
    reset = 1'b0;
    goto(n + 60);
    send_pkt(8'h4B, 8'h1B, 1'b1, n);
    push_chk(n + 1,       1'b0, 1'b1, 1'b0, "post_rst_start");
    push_chk(n + LEN + 1, 1'b1, 1'b0, 1'b1, "post_rst_done");
    goto(n + LEN + 10);

    final_chk = 1'b1;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_state_uart_tx.md
Name: game_state_uart_tx

Overview:
- UART transmitter that serializes the current game-state snapshot onto `serial_out`.
- The peer board's receiver consumes the stream on its `serial_in`.
- Runs in the VGA_CLK domain (25 MHz). The top level fires `send` on round events, for example when `resume` pulses or a door is set.
- Frame format: header byte, state byte, status byte, and an optional checksum byte. Each byte is sent as 8N1, LSB first.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200). Legal range is 2 or more.
- HEADER, 8'hA5, first byte of every packet.

Ports:
- clk  in  1  VGA_CLK domain clock.
- reset  in  1  synchronous, active-high reset.
- send  in  1  request to transmit one packet. Sampled only in IDLE.
- correct_door_1  in  2  door index, player 1.
- correct_door_2  in  2  door index, player 2.
- player_1_pos  in  2  player 1 position.
- player_2_pos  in  2  player 2 position.
- p1_lives  in  2  player 1 lives.
- p2_lives  in  2  player 2 lives.
- time_up  in  1  round-timer expired flag.
- serial_out  out  1  UART line. Idles high.
- busy  out  1  high from acceptance of `send` until the packet completes.
- done  out  1  one-cycle pulse at packet completion.

Behaviour:
- Reset values: serial_out=1, busy=0, done=0, FSM=IDLE, bit counter=0, byte index=0, baud counter=0. Reset has priority over all other inputs.
- Snapshot: when `send`=1 in IDLE at edge N, latch every state input into the packet registers. Later input changes do not affect the packet in flight.
  - byte0 = HEADER
  - byte1 = {correct_door_1, correct_door_2, player_1_pos, player_2_pos}
  - byte2 = {3'b000, time_up, p1_lives, p2_lives}
- FSM states: IDLE -> START -> DATA -> STOP -> (START for next byte | DONE) -> IDLE.
- Latency: busy=1 and serial_out=0 (start bit) from edge N+1.
- Each bit is held for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and the bit advances when it wraps.
- DATA: 8 bits, LSB first, bit index 0..7.
- STOP: line held high for 1 bit time. If bytes remain, go to START with no idle gap. Otherwise go to DONE.
- DONE: lasts one cycle. done=1, busy=0, serial_out=1. FSM returns to IDLE on the next edge.
- Packet length: NBYTES*10*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit. NBYTES is 3, or 4 with the checksum enabled.
- A new `send` is accepted in the IDLE cycle after DONE at the earliest.
- `send` while busy=1 (including the DONE cycle) is ignored. It is not queued.
- `send` held high continuously: packets go out back-to-back, separated by exactly 1 DONE cycle plus 1 IDLE acceptance cycle.
- Reset mid-packet: on the next edge serial_out=1, busy=0, done=0. No partial byte completion.
- Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits, bit index 3 bits, byte index 2 bits. No arithmetic overflow is reachable.

Optional Feature:
- Macro: PACKET_CHECKSUM_EN.
- Defined: a fourth byte, byte3 = byte0 ^ byte1 ^ byte2, is sent after byte2 under the same 8N1 rules. NBYTES=4.
- Undefined: the packet ends after byte2 and no checksum logic exists.

Test Plan (CLKS_PER_BIT=4):
- Reset idle: assert reset 3 cycles, then release with send=0 for 50 cycles -> serial_out=1, busy=0, done=0 throughout.
- Basic packet: door1=01, door2=00, p1pos=10, p2pos=11, time_up=1, p1_lives=10, p2_lives=11; pulse send at edge N.
  - serial_out=0 at N+1; busy rises at N+1.
  - Sampling mid-bit decodes 0xA5, 0x4B, 0x1B, each with stop bit=1.
  - done pulses exactly at N+121 (N+161 with PACKET_CHECKSUM_EN, with fourth byte 0xF5); busy low from that cycle.
- Snapshot hold: change all state inputs to 0 at N+5 during byte0 -> bytes are still 0x4B and 0x1B.
- Ignored send: pulse send at N+30 and N+90 mid-packet -> exactly one done pulse and no second packet; serial_out=1 after done.
- Back-to-back: hold send high for 300 cycles -> successive start bits are separated by 2 cycles after each done; all packets are correct.
- Reset mid-frame: assert reset at N+45 (during byte1) -> serial_out=1 and busy=0 at N+46, no done pulse; a following send yields a clean full packet.
